// File: rtl/encode_8_3_pkg.sv
// Shared constants and FSM state type for the 8-to-3 request encoder.
package encode_8_3_pkg;
  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick_8.sv
// Combinational picker: round-robin from a start pointer, or fixed highest-index priority.
module rr_pick_8
  import encode_8_3_pkg::*;
(
  input  logic [N-1:0] c_i,
  input  logic [W-1:0] ptr_i,
  input  logic         rr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = |c_i;
    if (rr_i) begin
      // Scan offsets downward so the surviving hit is the first set bit at or after ptr.
      for (int k = N - 1; k >= 0; k--) begin
        if (c_i[ptr_i + W'(k)]) idx_o = ptr_i + W'(k);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (c_i[i]) idx_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/encode_8_3.sv
// Registered priority encoder with pending-request capture, valid/ack handshake and overflow flag.
module encode_8_3
  import encode_8_3_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] In,
  input  logic         ack,
  output logic [W-1:0] Out,
  output logic         V,
  output logic [N-1:0] Pend,
  output logic         Ovf
);

  state_e         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           v_q, v_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic [N-1:0]   cap, cand, serve_oh;
  logic [W-1:0]   pick_idx;
  logic           pick_found;
  logic           serve;

  assign cap  = E ? In : '0;
  assign cand = pend_q | cap;

  rr_pick_8 u_pick (
    .c_i     (cand),
    .ptr_i   (ptr_q),
    .rr_i    (RR != 0),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign serve    = E && pick_found && ((state_q == IDLE) || ack);
  assign serve_oh = serve ? (N'(1) << pick_idx) : '0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    out_d   = out_q;
    v_d     = v_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q | (|(cap & pend_q & ~serve_oh));
    // A served bit that came only from In is consumed; if it was already pending, a same-edge In bit re-arms it.
    pend_d  = (pend_q & ~serve_oh) | (cap & ~(serve_oh & ~pend_q));

    if (serve) begin
      state_d = HOLD;
      out_d   = pick_idx;
      v_d     = 1'b1;
      if (RR != 0) ptr_d = pick_idx + W'(1);
    end else if ((state_q == HOLD) && ack) begin
      state_d = IDLE;
      v_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      v_q     <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      v_q     <= v_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Out  = out_q;
  assign V    = v_q;
  assign Pend = pend_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_encode_8_3.sv
// Bench for encode_8_3: directed scenarios plus a randomized run against a behavioural model.
module tb_encode_8_3;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [7:0] in_r;
  logic       ack;
  logic [2:0] out_a, out_b;
  logic       v_a, v_b, ovf_a, ovf_b;
  logic [7:0] pend_a, pend_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: index 0 tracks the RR=1 device, index 1 the RR=0 device.
  logic [2:0] m_out [2];
  logic       m_v   [2];
  logic [7:0] m_pend[2];
  logic       m_ovf [2];
  logic [2:0] m_ptr [2];

  encode_8_3 #(.RR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .E(e), .In(in_r), .ack(ack),
    .Out(out_a), .V(v_a), .Pend(pend_a), .Ovf(ovf_a)
  );

  encode_8_3 #(.RR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .E(e), .In(in_r), .ack(ack),
    .Out(out_b), .V(v_b), .Pend(pend_b), .Ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] m_pick(input logic [7:0] c, input logic [2:0] p, input bit rr);
    if (rr) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (int'(p) + k) % 8;
        if (c[i]) return 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) if (c[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = '0; m_v[d] = 1'b0; m_pend[d] = '0; m_ovf[d] = 1'b0; m_ptr[d] = '0;
    end
  endtask

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] capv, cand, served;
      logic [2:0] idx;
      bit go;
      capv   = e ? in_r : 8'h00;
      cand   = m_pend[d] | capv;
      go     = e && (cand != 0) && (!m_v[d] || ack);
      served = 8'h00;
      idx    = 3'd0;
      if (go) begin
        idx      = m_pick(cand, m_ptr[d], d == 0);
        served   = 8'h01 << idx;
        m_out[d] = idx;
        m_v[d]   = 1'b1;
        if (d == 0) m_ptr[d] = 3'((int'(idx) + 1) % 8);
      end else if (m_v[d] && ack) begin
        m_v[d] = 1'b0;
      end
      if ((capv & m_pend[d] & ~served) != 0) m_ovf[d] = 1'b1;
      if (go && !m_pend[d][idx]) m_pend[d] = (m_pend[d] | capv) & ~served;
      else                       m_pend[d] = (m_pend[d] & ~served) | capv;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    in_r = 8'h00; e = 1'b1; ack = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; e = 1'b1; in_r = 8'hFF; ack = 1'b0;
    m_reset();
    #2;
    checks++;
    if ({out_a, v_a, pend_a, ovf_a} !== 13'd0 || {out_b, v_b, pend_b, ovf_b} !== 13'd0) begin
      errors++;
      $display("FAIL reset_async: a=%h b=%h want 0", {out_a, v_a, pend_a, ovf_a}, {out_b, v_b, pend_b, ovf_b});
    end
    @(posedge clk); #1;
    checks++;
    if ({out_a, v_a, pend_a} !== 12'd0) begin
      errors++; $display("FAIL reset_hold_edge: a=%h want 0", {out_a, v_a, pend_a});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_a !== 3'd0 || v_a !== 1'b1 || out_b !== 3'd7) begin
      errors++; $display("FAIL reset_first: out_a=%0d v_a=%0d out_b=%0d want 0 1 7", out_a, v_a, out_b);
    end
    in_r = 8'h00; ack = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if (out_a !== 3'(k) || v_a !== 1'b1 || out_b !== 3'(7 - k) || v_b !== 1'b1) begin
        errors++;
        $display("FAIL reset_seq%0d: out_a=%0d v_a=%0d out_b=%0d v_b=%0d want %0d 1 %0d 1", k, out_a, v_a, out_b, v_b, k, 7 - k);
      end
    end
    tick();
    checks++;
    if (v_a !== 1'b0 || v_b !== 1'b0 || out_a !== 3'd7 || out_b !== 3'd0) begin
      errors++; $display("FAIL reset_drain: v_a=%0d v_b=%0d out_a=%0d out_b=%0d want 0 0 7 0", v_a, v_b, out_a, out_b);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    in_r = 8'h81; ack = 1'b1;
    tick();
    checks++;
    if (out_a !== 3'd0 || v_a !== 1'b1 || out_b !== 3'd7) begin
      errors++; $display("FAIL rr_first: out_a=%0d v_a=%0d out_b=%0d want 0 1 7", out_a, v_a, out_b);
    end
    in_r = 8'h00;
    tick();
    checks++;
    if (out_a !== 3'd7 || v_a !== 1'b1 || out_b !== 3'd0) begin
      errors++; $display("FAIL rr_second: out_a=%0d v_a=%0d out_b=%0d want 7 1 0", out_a, v_a, out_b);
    end
    tick();
    checks++;
    if (v_a !== 1'b0 || v_b !== 1'b0) begin
      errors++; $display("FAIL rr_idle: v_a=%0d v_b=%0d want 0 0", v_a, v_b);
    end
    in_r = 8'h81;
    tick();
    checks++;
    if (out_a !== 3'd0 || v_a !== 1'b1) begin
      errors++; $display("FAIL rr_ptr_wrapped: out_a=%0d v_a=%0d want 0 1", out_a, v_a);
    end
    in_r = 8'h00;
    tick(); tick();
  endtask

  task automatic test_fixed();
    logic [2:0] exp_b [3];
    logic [2:0] exp_a [3];
    exp_b[0] = 3'd5; exp_b[1] = 3'd2; exp_b[2] = 3'd1;
    exp_a[0] = 3'd1; exp_a[1] = 3'd2; exp_a[2] = 3'd5;
    do_reset();
    in_r = 8'b0010_0110; ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      in_r = 8'h00;
      checks++;
      if (out_b !== exp_b[k] || v_b !== 1'b1 || out_a !== exp_a[k] || v_a !== 1'b1) begin
        errors++;
        $display("FAIL fixed_seq%0d: out_b=%0d out_a=%0d want %0d %0d", k, out_b, out_a, exp_b[k], exp_a[k]);
      end
    end
    tick();
    checks++;
    if (v_b !== 1'b0 || v_a !== 1'b0) begin
      errors++; $display("FAIL fixed_idle: v_b=%0d v_a=%0d want 0 0", v_b, v_a);
    end
  endtask

  task automatic test_hold_ovf();
    logic [7:0] pulses [4];
    pulses[0] = 8'h00; pulses[1] = 8'h08; pulses[2] = 8'h00; pulses[3] = 8'h08;
    do_reset();
    ack = 1'b0; in_r = 8'h08;
    tick();
    for (int k = 0; k < 4; k++) begin
      in_r = pulses[k];
      tick();
      checks++;
      if (out_a !== 3'd3 || v_a !== 1'b1 || out_b !== 3'd3 || v_b !== 1'b1) begin
        errors++; $display("FAIL hold_stable%0d: out_a=%0d v_a=%0d want 3 1", k, out_a, v_a);
      end
      if (k == 1) begin
        checks++;
        if (pend_a !== 8'h08 || ovf_a !== 1'b0) begin
          errors++; $display("FAIL hold_repend: pend=%h ovf=%0d want 08 0", pend_a, ovf_a);
        end
      end
    end
    checks++;
    if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL hold_ovf: ovf_a=%0d ovf_b=%0d want 1 1", ovf_a, ovf_b);
    end
    in_r = 8'h00; ack = 1'b1;
    tick(); tick();
  endtask

  task automatic test_enable();
    do_reset();
    e = 1'b0; in_r = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (pend_a !== 8'h00 || v_a !== 1'b0 || pend_b !== 8'h00 || v_b !== 1'b0) begin
        errors++; $display("FAIL en_off%0d: pend=%h v=%0d want 00 0", k, pend_a, v_a);
      end
    end
    e = 1'b1; in_r = 8'h08; ack = 1'b0;
    tick();
    in_r = 8'h10;
    tick();
    checks++;
    if (out_a !== 3'd3 || v_a !== 1'b1 || pend_a !== 8'h10 || pend_b !== 8'h10) begin
      errors++; $display("FAIL en_setup: out=%0d v=%0d pend_a=%h pend_b=%h want 3 1 10 10", out_a, v_a, pend_a, pend_b);
    end
    e = 1'b0; in_r = 8'h00; ack = 1'b1;
    tick();
    checks++;
    if (v_a !== 1'b0 || pend_a !== 8'h10 || v_b !== 1'b0 || pend_b !== 8'h10 || out_a !== 3'd3) begin
      errors++; $display("FAIL en_ack: v=%0d pend=%h out=%0d want 0 10 3", v_a, pend_a, out_a);
    end
    e = 1'b1;
    tick();
    checks++;
    if (out_a !== 3'd4 || v_a !== 1'b1 || pend_a !== 8'h00) begin
      errors++; $display("FAIL en_resume: out=%0d v=%0d pend=%h want 4 1 00", out_a, v_a, pend_a);
    end
    tick();
  endtask

  task automatic test_reset_hold();
    do_reset();
    ack = 1'b0; in_r = 8'h0D;
    tick();
    in_r = 8'h00;
    checks++;
    if (out_a !== 3'd0 || v_a !== 1'b1 || pend_a !== 8'h0C) begin
      errors++; $display("FAIL rh_setup: out=%0d v=%0d pend=%h want 0 1 0C", out_a, v_a, pend_a);
    end
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (v_a !== 1'b0 || pend_a !== 8'h00 || v_b !== 1'b0 || pend_b !== 8'h00 || out_a !== 3'd0) begin
      errors++; $display("FAIL rh_async: v=%0d pend=%h out=%0d want 0 00 0", v_a, pend_a, out_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0 || pend_a !== 8'h00) begin
        errors++; $display("FAIL rh_quiet%0d: v_a=%0d v_b=%0d pend=%h want 0 0 00", k, v_a, v_b, pend_a);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      e    = ($urandom_range(0, 9) != 0);
      in_r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ack  = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({out_a, v_a, pend_a, ovf_a} !== {m_out[0], m_v[0], m_pend[0], m_ovf[0]}) begin
        errors++;
        $display("FAIL rand_a@%0d: got out=%0d v=%0d pend=%h ovf=%0d want out=%0d v=%0d pend=%h ovf=%0d",
                 k, out_a, v_a, pend_a, ovf_a, m_out[0], m_v[0], m_pend[0], m_ovf[0]);
      end
      checks++;
      if ({out_b, v_b, pend_b, ovf_b} !== {m_out[1], m_v[1], m_pend[1], m_ovf[1]}) begin
        errors++;
        $display("FAIL rand_b@%0d: got out=%0d v=%0d pend=%h ovf=%0d want out=%0d v=%0d pend=%h ovf=%0d",
                 k, out_b, v_b, pend_b, ovf_b, m_out[1], m_v[1], m_pend[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; in_r = 8'h00; ack = 1'b0;
    m_reset();
    test_reset();
    test_rr_wrap();
    test_fixed();
    test_hold_ovf();
    test_enable();
    test_reset_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encode_8_3.md
ENCODE_8_3 -- requirements
Module: encode_8_3

Interface
REQ-001 SHALL have parameter RR, default 1: 1 = round-robin priority, 0 = fixed priority (highest index wins).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port E  input  1  enable; gates request capture and new selections.
REQ-005 SHALL have port In  input  8  request lines; bit i set = request for code i.
REQ-006 SHALL have port ack  input  1  consumer accepts current code when V=1.
REQ-007 SHALL have port Out  output  3  binary index of the served request; registered.
REQ-008 SHALL have port V  output  1  Out valid; registered.
REQ-009 SHALL have port Pend  output  8  pending-request register, visible for debug.
REQ-010 SHALL have port Ovf  output  1  sticky lost-request flag.

Function
REQ-011 SHALL keep an 8-bit pending register; with E=1, each edge ORs In into it.
REQ-012 SHALL define the candidate vector C = Pend | (E ? In : 0).
REQ-013 SHALL implement FSM states IDLE (V=0) and HOLD (V=1).
REQ-014 IDLE: on an edge with E=1 and C!=0, SHALL load Out with the selected index, set V=1, clear that bit in Pend, and go to HOLD.
REQ-015 SHALL give one-cycle latency: In asserted before edge N yields V=1 after edge N.
REQ-016 HOLD: Out and V SHALL stay stable until an edge with ack=1.
REQ-017 HOLD with ack=1, E=1, and the remaining C!=0 (C with the just-served bit excluded unless re-asserted on In) SHALL load the next index and stay in HOLD, giving back-to-back codes with no bubble.
REQ-018 HOLD with ack=1 and (E=0 or remaining C=0) SHALL set V=0 and go to IDLE; Out keeps its last value.
REQ-019 ack while V=0 SHALL be ignored.
REQ-020 With RR=1: search SHALL start at pointer ptr (3 bits), ascending with wrap 7->0; the first set bit wins; ptr SHALL update to the served index+1 mod 8 (7 wraps to 0).
REQ-021 With RR=0: the highest set index SHALL win, and ptr is unused.
REQ-022 An In bit equal to a bit being served on the same edge SHALL be recorded as a new pending request.
REQ-023 An In bit already set in Pend (not being cleared that edge) SHALL set Ovf=1; Ovf is cleared only by reset.
REQ-024 E=0 SHALL capture nothing and start no new selection; Pend is retained, and a HOLD transaction completes normally on ack.
REQ-025 The one-hot decode of Out SHALL always equal the bit just removed from the candidate set.

Reset
REQ-026 rst_n=0 SHALL immediately force Out=0, V=0, Pend=0, Ovf=0, ptr=0, state=IDLE, independent of clk.
REQ-027 Reset mid-HOLD SHALL drop the held code and all pending requests; no code is reissued after release.
REQ-028 The first edge after rst_n rises SHALL behave as normal IDLE operation.

Structure
REQ-029 Package encode_8_3_pkg SHALL hold constants N=8 and W=3 plus the state enum (IDLE, HOLD).
REQ-030 Selection logic SHALL be one combinational sub-module, rr_pick_8 (inputs C, ptr, RR; outputs index and found flag).
REQ-031 All outputs SHALL be driven directly from flops.

Verification
REQ-032 Reset with In=8'hFF held -> Out=0, V=0, Pend=0 while rst_n=0; after release with E=1: Out=0, then 1..7 in order with ack held 1, V continuous for 8 cycles.
REQ-033 RR=1, In=8'b1000_0001 pulsed once, ack=1 -> Out=0, then Out=7, then V=0; ptr ends at 0.
REQ-034 RR=0, In=8'b0010_0110 pulsed, ack=1 -> Out sequence 5, 2, 1, then V=0.
REQ-035 In=8'h08 pulsed, ack=0 for 5 cycles -> Out=3 and V=1 stable for 5 cycles; In=8'h08 pulsed again during this -> Pend=8'h08, Ovf=0; a third pulse before service -> Ovf=1.
REQ-036 E=0 with In=8'hF0 -> Pend and V stay 0; with Pend=8'h10 and E=0 in HOLD, ack -> V=0 and Pend=8'h10 retained.
REQ-037 rst_n pulsed low mid-HOLD with Pend=8'h0C -> V=0 and Pend=0 immediately; no output after release until new In.
